ysyx_22041207_rd_resp: RTL and testbench

Read-channel responder for the instruction/data fetch bus: the slave end of the `rx_r_*` / `rx_data_*` handshake that the fetch stage drives as initiator. It accepts one read address at a time, waits a configurable number of cycles, and reads an aligned 64-bit word from a backing memory port. It then returns the byte-shifted, size-masked data and holds it until the initiator acknowledges. It sits between the fetch stage and the simulation memory model, replacing direct combinational memory reads.

---
 rtl/ysyx_22041207_rd_resp.sv | 118 +++++++++++
 tb/tb_ysyx_22041207_rd_resp.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_22041207_rd_resp.sv
// Read-channel responder: accepts one fetch read, waits LATENCY cycles, returns byte-shifted masked data.
// Optional address range check is enabled by defining YSYX_22041207_RD_RESP_ERR_EN.
module ysyx_22041207_rd_resp #(
  parameter int unsigned LATENCY  = 1,
  parameter logic [63:0] MEM_BASE = 64'h8000_0000,
  parameter logic [63:0] MEM_SIZE = 64'h0800_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_r_valid_i,
  output logic        rx_r_ready_o,
  input  logic [63:0] rx_r_addr_i,
  input  logic [7:0]  rx_r_size_i,
  output logic [63:0] rx_data_read_o,
  output logic        rx_data_valid,
  input  logic        rx_data_ready,
  output logic        rx_data_err,
  output logic [63:0] mem_raddr,
  input  logic [63:0] mem_rdata,
  output logic [1:0]  dbg_state
);

  // Handshakes: a transfer on either channel happens on a rising edge where valid and ready are both high.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q;
  logic [2:0]  off_q;
  logic [7:0]  size_q;
  logic        err_q;
  logic        acc_err;
  logic        accept;
  logic        wait_done;
  logic        resp_done;
  logic [63:0] shifted;
  logic [63:0] lane_mask;

`ifdef YSYX_22041207_RD_RESP_ERR_EN
  assign acc_err = (rx_r_addr_i < MEM_BASE) || (rx_r_addr_i >= MEM_BASE + MEM_SIZE);
`else
  logic unused_cfg;
  assign unused_cfg = ^{MEM_BASE, MEM_SIZE};
  assign acc_err    = 1'b0;
`endif

  assign rx_r_ready_o = (state_q == S_IDLE);
  assign dbg_state    = state_q;
  assign accept       = (state_q == S_IDLE) && rx_r_valid_i;
  assign wait_done    = (state_q == S_WAIT) && (cnt_q == 4'd0);
  assign resp_done    = (state_q == S_RESP) && rx_data_ready;

  // Bytes above the top of the word shift in as zero; the access never spills into the next word.
  assign shifted = mem_rdata >> {off_q, 3'b000};

  always_comb begin
    lane_mask = '0;
    for (int i = 0; i < 8; i++) begin
      lane_mask[8*i +: 8] = {8{size_q[i]}};
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (rx_r_valid_i) state_d = S_WAIT;
      S_WAIT:  if (cnt_q == 4'd0) state_d = S_RESP;
      S_RESP:  if (rx_data_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q          <= '0;
      off_q          <= '0;
      size_q         <= '0;
      err_q          <= 1'b0;
      mem_raddr      <= '0;
      rx_data_read_o <= '0;
      rx_data_valid  <= 1'b0;
      rx_data_err    <= 1'b0;
    end else begin
      if (accept) begin
        off_q  <= rx_r_addr_i[2:0];
        size_q <= rx_r_size_i;
        cnt_q  <= CNT_INIT;
        err_q  <= acc_err;
        // A rejected address leaves the memory port pointing at the last legal word.
        if (!acc_err) mem_raddr <= {rx_r_addr_i[63:3], 3'b000};
      end
      if ((state_q == S_WAIT) && (cnt_q != 4'd0)) cnt_q <= cnt_q - 4'd1;
      if (wait_done) begin
        rx_data_read_o <= err_q ? 64'd0 : (shifted & lane_mask);
        rx_data_valid  <= 1'b1;
        rx_data_err    <= err_q;
      end
      if (resp_done) begin
        rx_data_valid <= 1'b0;
        rx_data_err   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ysyx_22041207_rd_resp.sv
// Bench for ysyx_22041207_rd_resp: two instances (LATENCY 1 and 4), vector table, hand sequences, random reads.
module tb_ysyx_22041207_rd_resp;

  localparam logic [63:0] BASE = 64'h8000_0000;
  localparam logic [63:0] SIZE = 64'h0800_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        r_valid [2];
  logic        r_ready [2];
  logic [63:0] r_addr  [2];
  logic [7:0]  r_size  [2];
  logic [63:0] rdata   [2];
  logic        d_valid [2];
  logic        d_ready [2];
  logic        d_err   [2];
  logic [63:0] raddr   [2];
  logic [63:0] mrdata  [2];
  logic [1:0]  dbg     [2];

  int tests = 0;
  int fails = 0;
  logic [63:0] last_ra [2];

  typedef struct {
    logic [63:0] addr;
    logic [7:0]  size;
    int          hold;
    logic [63:0] exp;
  } vec_t;
  vec_t vecs [7];

  always #5 clk = ~clk;

  ysyx_22041207_rd_resp #(.LATENCY(1)) u_lat1 (
    .clk(clk), .rst(rst),
    .rx_r_valid_i(r_valid[0]), .rx_r_ready_o(r_ready[0]),
    .rx_r_addr_i(r_addr[0]), .rx_r_size_i(r_size[0]),
    .rx_data_read_o(rdata[0]), .rx_data_valid(d_valid[0]),
    .rx_data_ready(d_ready[0]), .rx_data_err(d_err[0]),
    .mem_raddr(raddr[0]), .mem_rdata(mrdata[0]), .dbg_state(dbg[0])
  );

  ysyx_22041207_rd_resp #(.LATENCY(4)) u_lat4 (
    .clk(clk), .rst(rst),
    .rx_r_valid_i(r_valid[1]), .rx_r_ready_o(r_ready[1]),
    .rx_r_addr_i(r_addr[1]), .rx_r_size_i(r_size[1]),
    .rx_data_read_o(rdata[1]), .rx_data_valid(d_valid[1]),
    .rx_data_ready(d_ready[1]), .rx_data_err(d_err[1]),
    .mem_raddr(raddr[1]), .mem_rdata(mrdata[1]), .dbg_state(dbg[1])
  );

  // Backing memory: one known word at BASE, address-derived content elsewhere.
  function automatic logic [63:0] mem_word(input logic [63:0] a);
    if (a == BASE) return 64'h1122_3344_5566_7788;
    return {~a[31:0], a[31:0] ^ 32'h5A5A_C3C3};
  endfunction

  always_comb begin
    mrdata[0] = mem_word(raddr[0]);
    mrdata[1] = mem_word(raddr[1]);
  end

  // Reference: result byte i is memory byte (i + offset) when enabled and still inside the word.
  function automatic logic [63:0] model(input logic [63:0] addr, input logic [7:0] size);
    logic [63:0] w;
    logic [63:0] res;
    int off;
    w   = mem_word({addr[63:3], 3'b000});
    off = int'(addr[2:0]);
    res = '0;
    for (int i = 0; i < 8; i++) begin
      if (size[i] && (i + off) < 8) res[i*8 +: 8] = w[(i+off)*8 +: 8];
    end
    return res;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // flags: [0] accepted, [1] ready low while waiting, [2] response held stable, [3] clean completion
  task automatic run_read(input int idx, input logic [63:0] addr, input logic [7:0] size, input int hold,
                          output logic [63:0] data, output int lat, output logic err,
                          output logic [63:0] ra, output logic [3:0] flags);
    int n;
    flags = 4'b1111;
    lat   = 0;
    data  = '0;
    err   = 1'b0;
    ra    = '0;
    @(negedge clk);
    r_valid[idx] = 1'b1;
    r_addr[idx]  = addr;
    r_size[idx]  = size;
    n = 0;
    while (r_ready[idx] !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) begin
      flags[0] = 1'b0;
      r_valid[idx] = 1'b0;
      return;
    end
    @(posedge clk);
    @(negedge clk);
    r_valid[idx] = 1'b0;
    r_addr[idx]  = {$urandom, $urandom};
    r_size[idx]  = 8'($urandom);
    do begin
      if (r_ready[idx] !== 1'b0) flags[1] = 1'b0;
      @(posedge clk);
      lat++;
      @(negedge clk);
    end while (d_valid[idx] !== 1'b1 && lat < 32);
    if (d_valid[idx] !== 1'b1) begin
      flags[1] = 1'b0;
      return;
    end
    data = rdata[idx];
    err  = d_err[idx];
    ra   = raddr[idx];
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (d_valid[idx] !== 1'b1 || rdata[idx] !== data || d_err[idx] !== err || r_ready[idx] !== 1'b0)
        flags[2] = 1'b0;
    end
    d_ready[idx] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    d_ready[idx] = 1'b0;
    if (d_valid[idx] !== 1'b0 || r_ready[idx] !== 1'b1 || d_err[idx] !== 1'b0 || rdata[idx] !== data)
      flags[3] = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] data, ra, a, exp_d, exp_ra;
    logic [7:0]  sz;
    logic [3:0]  flags;
    logic        err, exp_err;
    int          lat, idx, seen;

    vecs[0] = '{64'h8000_0004, 8'h0F, 3, 64'h0000_0000_1122_3344};
    vecs[1] = '{64'h8000_0000, 8'hFF, 0, 64'h1122_3344_5566_7788};
    vecs[2] = '{64'h8000_0000, 8'h0F, 1, 64'h0000_0000_5566_7788};
    vecs[3] = '{64'h8000_0007, 8'hFF, 2, 64'h0000_0000_0000_0011};
    vecs[4] = '{64'h8000_0003, 8'hF0, 0, 64'h0000_0011_0000_0000};
    vecs[5] = '{64'h8000_0002, 8'h3C, 1, 64'h0000_1122_3344_0000};
    vecs[6] = '{64'h8000_0005, 8'h01, 0, 64'h0000_0000_0000_0033};

    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      r_valid[i] = 1'b0; r_addr[i] = '0; r_size[i] = '0; d_ready[i] = 1'b0; last_ra[i] = '0;
    end

    // Reset state, with a request and an ack offered while reset is held.
    #3;
    for (int i = 0; i < 2; i++) begin
      check("rst_ready", 64'(r_ready[i]), 64'd1);
      check("rst_valid", 64'(d_valid[i]), 64'd0);
      check("rst_data", rdata[i], 64'd0);
      check("rst_raddr", raddr[i], 64'd0);
      check("rst_err", 64'(d_err[i]), 64'd0);
    end
    r_valid[0] = 1'b1; r_addr[0] = BASE; r_size[0] = 8'hFF; d_ready[1] = 1'b1;
    repeat (2) @(negedge clk);
    r_valid[0] = 1'b0; d_ready[1] = 1'b0;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_no_accept_valid", 64'(d_valid[0]), 64'd0);
    check("rst_no_accept_raddr", raddr[0], 64'd0);

    // Ack pulses in IDLE do nothing.
    d_ready[0] = 1'b1; d_ready[1] = 1'b1;
    repeat (2) @(negedge clk);
    d_ready[0] = 1'b0; d_ready[1] = 1'b0;
    for (int i = 0; i < 2; i++) begin
      check("idle_ack_valid", 64'(d_valid[i]), 64'd0);
      check("idle_ack_ready", 64'(r_ready[i]), 64'd1);
    end

    // Vector table on the LATENCY=1 instance.
    for (int v = 0; v < 7; v++) begin
      run_read(0, vecs[v].addr, vecs[v].size, vecs[v].hold, data, lat, err, ra, flags);
      check($sformatf("vec%0d_data", v), data, vecs[v].exp);
      check($sformatf("vec%0d_lat", v), 64'(lat), 64'd1);
      check($sformatf("vec%0d_raddr", v), ra, BASE);
      check($sformatf("vec%0d_err", v), 64'(err), 64'd0);
      check($sformatf("vec%0d_flags", v), 64'(flags), 64'hF);
    end
    last_ra[0] = BASE;

    // LATENCY=4 full-word read.
    run_read(1, BASE, 8'hFF, 2, data, lat, err, ra, flags);
    check("lat4_data", data, 64'h1122_3344_5566_7788);
    check("lat4_lat", 64'(lat), 64'd4);
    check("lat4_raddr", ra, BASE);
    check("lat4_flags", 64'(flags), 64'hF);
    last_ra[1] = BASE;

    // Back-to-back on LATENCY=1 with request and ack held high.
    @(negedge clk);
    d_ready[0] = 1'b1; r_valid[0] = 1'b1; r_addr[0] = BASE; r_size[0] = 8'h0F;
    check("b2b_ready_e0", 64'(r_ready[0]), 64'd1);
    @(posedge clk); @(negedge clk);
    r_addr[0] = BASE + 64'd4;
    check("b2b_ready_e1", 64'(r_ready[0]), 64'd0);
    check("b2b_valid_e1", 64'(d_valid[0]), 64'd0);
    @(posedge clk); @(negedge clk);
    check("b2b_valid_e2", 64'(d_valid[0]), 64'd1);
    check("b2b_data1", rdata[0], 64'h5566_7788);
    @(posedge clk); @(negedge clk);
    check("b2b_valid_e3", 64'(d_valid[0]), 64'd0);
    check("b2b_ready_e3", 64'(r_ready[0]), 64'd1);
    @(posedge clk); @(negedge clk);
    r_valid[0] = 1'b0;
    check("b2b_ready_e4", 64'(r_ready[0]), 64'd0);
    @(posedge clk); @(negedge clk);
    check("b2b_valid_e5", 64'(d_valid[0]), 64'd1);
    check("b2b_data2", rdata[0], 64'h1122_3344);
    @(posedge clk); @(negedge clk);
    d_ready[0] = 1'b0;
    check("b2b_done", 64'(d_valid[0]), 64'd0);

    // Reset in the middle of a LATENCY=4 wait.
    r_valid[1] = 1'b1; r_addr[1] = BASE + 64'd8; r_size[1] = 8'hFF;
    @(posedge clk); @(negedge clk);
    r_valid[1] = 1'b0;
    @(posedge clk); @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_ready", 64'(r_ready[1]), 64'd1);
    check("mid_rst_valid", 64'(d_valid[1]), 64'd0);
    check("mid_rst_data", rdata[1], 64'd0);
    check("mid_rst_raddr", raddr[1], 64'd0);
    last_ra[0] = '0; last_ra[1] = '0;
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (d_valid[1] === 1'b1) seen++;
    end
    check("mid_rst_no_valid", 64'(seen), 64'd0);
    run_read(1, BASE + 64'd1, 8'h7F, 1, data, lat, err, ra, flags);
    check("post_rst_data", data, model(BASE + 64'd1, 8'h7F));
    check("post_rst_lat", 64'(lat), 64'd4);
    check("post_rst_flags", 64'(flags), 64'hF);
    last_ra[1] = BASE;

`ifdef YSYX_22041207_RD_RESP_ERR_EN
    run_read(0, 64'h0000_1000, 8'hFF, 2, data, lat, err, ra, flags);
    check("err_data", data, 64'd0);
    check("err_flag", 64'(err), 64'd1);
    check("err_lat", 64'(lat), 64'd1);
    check("err_raddr", ra, last_ra[0]);
    check("err_flags", 64'(flags), 64'hF);
`endif

    // Random reads checked against the byte-level model.
    for (int n = 0; n < 40; n++) begin
      idx = int'($urandom_range(0, 1));
      a   = BASE + 64'($urandom_range(0, 255));
`ifdef YSYX_22041207_RD_RESP_ERR_EN
      if ($urandom_range(0, 3) == 0) a = {$urandom, $urandom};
      exp_err = (a < BASE) || (a >= BASE + SIZE);
`else
      exp_err = 1'b0;
`endif
      sz     = 8'($urandom_range(0, 255));
      exp_d  = exp_err ? 64'd0 : model(a, sz);
      exp_ra = exp_err ? last_ra[idx] : {a[63:3], 3'b000};
      run_read(idx, a, sz, int'($urandom_range(0, 3)), data, lat, err, ra, flags);
      check($sformatf("rnd%0d_data", n), data, exp_d);
      check($sformatf("rnd%0d_lat", n), 64'(lat), (idx == 0) ? 64'd1 : 64'd4);
      check($sformatf("rnd%0d_err", n), 64'(err), 64'(exp_err));
      check($sformatf("rnd%0d_raddr", n), ra, exp_ra);
      check($sformatf("rnd%0d_flags", n), 64'(flags), 64'hF);
      last_ra[idx] = exp_ra;
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
